// File: rtl/inst_buffer_if.sv
// Bundle of the decode-side push port and issue-side pop port of the instruction queue.
// The queue itself takes the slave modport; the surrounding pipeline drives the master side.
interface inst_buffer_if #(
  parameter int INST_W = 32,
  parameter int DEPTH  = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                   flush_i;
  logic [1:0][INST_W-1:0] inst_i;
  logic [1:0]             inst_valid_i;
  logic                   ready_o;
  logic [1:0][INST_W-1:0] inst_o;
  logic [1:0]             inst_valid_o;
  logic [1:0]             issue_i;
  logic                   stall_i;
  logic [CW-1:0]          count_o;

  modport master (
    output flush_i, inst_i, inst_valid_i, issue_i, stall_i,
    input  ready_o, inst_o, inst_valid_o, count_o
  );

  modport slave (
    input  flush_i, inst_i, inst_valid_i, issue_i, stall_i,
    output ready_o, inst_o, inst_valid_o, count_o
  );
endinterface

// File: rtl/inst_buffer.sv
// Dual-port circular instruction queue between decode and issue: up to two in and
// two out per cycle, head pair exposed in program order, flushable on redirect.
module inst_buffer #(
  parameter int DEPTH  = 8,
  parameter int INST_W = 32
) (
  input  logic         clk,
  input  logic         rst,
  inst_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [INST_W-1:0] mem [DEPTH];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [PW-1:0]     head_nx1;
  logic [PW-1:0]     tail_nx1;
  logic [CW-1:0]     count;
  logic              ready;
  logic              clear;
  logic [1:0]        push_n;
  logic [1:0]        pop_n;

  // Ready looks only at registered occupancy so the frontend never depends on a same-cycle pop.
  assign ready    = (count <= CW'(DEPTH - 2));
  assign clear    = rst | bus.flush_i;
  assign head_nx1 = head + PW'(1);
  assign tail_nx1 = tail + PW'(1);

  always_comb begin
    push_n = 2'd0;
    if (ready) begin
      push_n = {1'b0, bus.inst_valid_i[0]} + {1'b0, bus.inst_valid_i[1]};
    end
  end

  // Issue bits on slots that hold no valid entry are ignored.
  always_comb begin
    pop_n = 2'd0;
    if (!bus.stall_i) begin
      case (bus.issue_i)
        2'b11: begin
          if (count >= CW'(2))      pop_n = 2'd2;
          else if (count != '0)     pop_n = 2'd1;
        end
        2'b01: begin
          if (count != '0)          pop_n = 2'd1;
        end
        default: pop_n = 2'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(pop_n);
      tail  <= tail + PW'(push_n);
      count <= count + CW'(push_n) - CW'(pop_n);
    end
  end

  // Storage is never cleared; occupancy alone qualifies the outputs.
  always_ff @(posedge clk) begin
    if (!clear && ready) begin
      case (bus.inst_valid_i)
        2'b11: begin
          mem[tail]     <= bus.inst_i[0];
          mem[tail_nx1] <= bus.inst_i[1];
        end
        2'b01:   mem[tail] <= bus.inst_i[0];
        2'b10:   mem[tail] <= bus.inst_i[1];
        default: ;
      endcase
    end
  end

  assign bus.inst_o[0]     = mem[head];
  assign bus.inst_o[1]     = mem[head_nx1];
  assign bus.inst_valid_o  = {(count >= CW'(2)), (count != '0)};
  assign bus.ready_o       = ready;
  assign bus.count_o       = count;
endmodule

// File: doc/inst_buffer.md
# inst_buffer

Dual-port instruction queue between the decode stage and the issue stage of the two-pipe backend. It accepts up to two decoded `inst_t` entries per cycle from the frontend and presents the two oldest entries, in program order, to the issue logic. It retires 0, 1 or 2 entries per cycle according to the issue decision. A flush discards all contents on a redirect (branch mispredict, exception, ertn).

## Interface
Parameters:
- `DEPTH`, default 8: number of entries. Must be a power of two and ≥ 4.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush_i`  in  1  discard all entries; highest priority.
- `inst_i`  in  2×inst_t  decoded instructions; slot 0 is older.
- `inst_valid_i`  in  2  per-slot valid.
- `ready_o`  out  1  buffer can take two entries this cycle.
- `inst_o`  out  2×inst_t  head entries; slot 0 is oldest.
- `inst_valid_o`  out  2  per-slot valid for `inst_o`.
- `issue_i`  in  2  issue decision for `inst_o`. Legal values are 2'b00, 2'b01, 2'b11.
- `stall_i`  in  1  backend stall; no entry retires while high.
- `count_o`  out  $clog2(DEPTH)+1  current occupancy.

## Operation
Storage is a circular array of DEPTH `inst_t` entries with a head pointer, a tail pointer (both $clog2(DEPTH) bits, wrapping naturally) and an occupancy counter.

Push:
- Push is allowed only when `ready_o`=1. `ready_o` = (count ≤ DEPTH−2) and depends only on registered count, never on same-cycle pop.
- Valid input slots are compacted in order. 2'b11 writes `inst_i[0]` at tail and `inst_i[1]` at tail+1. 2'b01 writes `inst_i[0]` at tail. 2'b10 writes `inst_i[1]` at tail.
- Tail advances by popcount(`inst_valid_i`).
- Inputs presented while `ready_o`=0 are dropped. The frontend must hold them.

Pop:
- `inst_o[0]` = entry[head]; `inst_o[1]` = entry[head+1]. These are combinational reads of registered storage.
- `inst_valid_o[0]` = count ≥ 1; `inst_valid_o[1]` = count ≥ 2.
- Pop count n = 0 if `stall_i`=1. Otherwise n = 2 for `issue_i`=2'b11, n = 1 for 2'b01, and n = 0 for 2'b00 or 2'b10 (2'b10 is illegal; a bench assertion fires).
- n is then masked by validity: an `issue_i` bit set on an invalid slot does not pop.
- Head advances by n.

Count update:
- count_next = count + pushed − n. Push and pop in the same cycle are both applied.
- Count can never exceed DEPTH, because `ready_o` guarantees 2 free slots before any push.

Flush and reset:
- `flush_i`=1: head, tail and count go to 0 next cycle. Any push and any pop in that cycle are ignored.
- `rst` has identical effect and dominates `flush_i`.
- Entry contents are not cleared; the valids gate them.

## Timing
- Reset values: count 0, head 0, tail 0. Hence `ready_o`=1, `inst_valid_o`=2'b00, `count_o`=0. `inst_o` contents are don't-care.
- Write-to-visible latency is 1 cycle. An instruction pushed in cycle t appears on `inst_o` in cycle t+1 at the earliest, with no bypass from `inst_i` to `inst_o`.
- A pop in cycle t takes effect in cycle t+1: the next entries shift into slots 0/1.
- Throughput: 2 in and 2 out every cycle in steady state.
- `ready_o` deasserts the cycle after count reaches DEPTH−1. With DEPTH=8, a push bringing count from 6 to 8 makes `ready_o`=0 next cycle.
- Wrap-around: pointers roll from DEPTH−1 to 0 with no bubble. The head+1 read wraps the same way.
- Flush in cycle t: `inst_valid_o`=2'b00 and `ready_o`=1 in cycle t+1.

## Test plan
- Reset, then no stimulus for 3 cycles → `inst_valid_o`=00, `ready_o`=1, `count_o`=0 every cycle.
- Push pairs A/B, C/D, E/F, G/H on consecutive cycles with `issue_i`=00 (DEPTH=8):
  - count 2, 4, 6, 8;
  - `ready_o`=0 after the 4th push;
  - `inst_o`={B,A} with valid 11.
- From full, `issue_i`=11 each cycle → outputs C/D, then E/F, then G/H, then valid 00. `ready_o` reasserts once count ≤6.
- Steady stream: push 2/cycle with `issue_i`=11 for 20 cycles → count holds at 2 after cycle 1, order preserved across ≥2 pointer wraps, no drops.
- Single-slot cases:
  - push 01 (X) with `issue_i`=01 while head=A → A retires, X enqueued, count unchanged.
  - push 10 (Y) → Y is written at tail, compacted.
  - `stall_i`=1 with `issue_i`=11 → no pop.
- Flush while count=5 and a simultaneous push of 11 → next cycle count 0, valid 00. A subsequent push of P/Q → `inst_o`={Q,P}.
